// File: rtl/call_return_if.sv
// call_return_if
//   Bundles the decode-side request signals and the return-address-stack
//   signals seen by call_return_ctrl.
//   Modports:
//     master - the controller: drives stack strobes/data, stall, redirect, faults
//     slave  - the surroundings (decode stage + stack): drive requests and flags
//   Parameter DATA_W sets the address/data width.
interface call_return_if #(
    parameter int DATA_W = 32
);
    logic              call_valid;
    logic              ret_valid;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] call_target;
    logic              fault_clear;
    logic [DATA_W-1:0] stk_rdata;
    logic              stk_empty;
    logic              stk_full;
    logic              stk_push;
    logic              stk_pop;
    logic [DATA_W-1:0] stk_wdata;
    logic              stall;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              fault_overflow;
    logic              fault_underflow;
    logic              depth_err;

    modport master (
        input  call_valid, ret_valid, pc_in, call_target, fault_clear,
               stk_rdata, stk_empty, stk_full,
        output stk_push, stk_pop, stk_wdata, stall, redirect_valid,
               redirect_pc, fault_overflow, fault_underflow, depth_err
    );

    modport slave (
        output call_valid, ret_valid, pc_in, call_target, fault_clear,
               stk_rdata, stk_empty, stk_full,
        input  stk_push, stk_pop, stk_wdata, stall, redirect_valid,
               redirect_pc, fault_overflow, fault_underflow, depth_err
    );
endinterface

// File: rtl/call_return_ctrl.sv
// call_return_ctrl
//   CALL/RET control stage in front of the return-address stack. Turns decode
//   requests into single-cycle push/pop strobes plus a fetch redirect, stalls
//   decode for the strobe cycle and the flag settle cycle, and traps stack
//   overflow/underflow in a FAULT state until software pulses fault_clear.
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     bus    - call_return_if.master (requests, stack interface, stall,
//              redirect, fault flags, depth_err)
//   Optional feature: define CALL_RET_DEPTH_CHECK_EN to add an occupancy
//   counter cross-checked against stk_empty/stk_full (depth_err); otherwise
//   depth_err is tied low.
//
//   state  | meaning
//   IDLE   | waiting for CALL/RET; decisions made on stack flags
//   PUSH   | stk_push and redirect_valid asserted
//   POP    | stk_pop and redirect_valid asserted
//   SETTLE | stack flags/rdata catching up after the strobe
//   FAULT  | overflow/underflow trapped; stalled until fault_clear
module call_return_ctrl #(
    parameter int DATA_W      = 32,
    parameter int RET_OFFSET  = 1,
    parameter int STACK_DEPTH = 15,
    parameter int CNT_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    call_return_if.master        bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PUSH, S_POP, S_SETTLE, S_FAULT
    } state_t;

    localparam logic [DATA_W-1:0] RET_OFF = DATA_W'(RET_OFFSET);

    state_t            state_q, state_d;
    logic              ld_call, ld_ret, set_ov, set_un, clr_flt;
    logic              push_q, pop_q, redir_q, ov_q, un_q;
    logic [DATA_W-1:0] wdata_q, rpc_q;

    always_comb begin
        state_d = state_q;
        ld_call = 1'b0;
        ld_ret  = 1'b0;
        set_ov  = 1'b0;
        set_un  = 1'b0;
        clr_flt = 1'b0;
        case (state_q)
            S_IDLE: begin
                // CALL has priority; a simultaneous RET stays stalled.
                if (bus.call_valid) begin
                    if (bus.stk_full) begin
                        state_d = S_FAULT;
                        set_ov  = 1'b1;
                    end else begin
                        state_d = S_PUSH;
                        ld_call = 1'b1;
                    end
                end else if (bus.ret_valid) begin
                    if (bus.stk_empty) begin
                        state_d = S_FAULT;
                        set_un  = 1'b1;
                    end else begin
                        state_d = S_POP;
                        ld_ret  = 1'b1;
                    end
                end
            end
            S_PUSH, S_POP: state_d = S_SETTLE;
            S_SETTLE:      state_d = S_IDLE;
            S_FAULT: begin
                if (bus.fault_clear) begin
                    state_d = S_IDLE;
                    clr_flt = 1'b1;
                end
            end
            default:       state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            redir_q <= 1'b0;
            ov_q    <= 1'b0;
            un_q    <= 1'b0;
            wdata_q <= '0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            // Strobes are registered copies of "entering PUSH/POP", so they
            // line up exactly with the PUSH/POP state cycle.
            push_q  <= (state_d == S_PUSH);
            pop_q   <= (state_d == S_POP);
            redir_q <= (state_d == S_PUSH) || (state_d == S_POP);
            if (ld_call) begin
                wdata_q <= bus.pc_in + RET_OFF;
                rpc_q   <= bus.call_target;
            end else if (ld_ret) begin
                rpc_q   <= bus.stk_rdata;
            end
            if (clr_flt) begin
                ov_q <= 1'b0;
                un_q <= 1'b0;
            end else begin
                if (set_ov) ov_q <= 1'b1;
                if (set_un) un_q <= 1'b1;
            end
        end
    end

    assign bus.stk_push        = push_q;
    assign bus.stk_pop         = pop_q;
    assign bus.redirect_valid  = redir_q;
    assign bus.stk_wdata       = wdata_q;
    assign bus.redirect_pc     = rpc_q;
    assign bus.fault_overflow  = ov_q;
    assign bus.fault_underflow = un_q;
    // Gated with rst_n so stall drops the instant reset is applied.
    assign bus.stall = rst_n & ((state_q != S_IDLE) | bus.call_valid | bus.ret_valid);

`ifdef CALL_RET_DEPTH_CHECK_EN
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

    logic [CNT_W-1:0] cnt_q;
    logic             derr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            derr_q <= 1'b0;
        end else begin
            if (push_q)
                cnt_q <= cnt_q + CNT_W'(1);
            else if (pop_q)
                cnt_q <= cnt_q - CNT_W'(1);
            // Flags are only trustworthy in IDLE, after the settle cycle.
            if ((state_q == S_IDLE) &&
                (((cnt_q == '0) != bus.stk_empty) || ((cnt_q == FULL_CNT) != bus.stk_full)))
                derr_q <= 1'b1;
        end
    end

    assign bus.depth_err = derr_q;
`else
    assign bus.depth_err = 1'b0;
`endif
endmodule

// File: tb/tb_call_return_ctrl.sv
module tb_call_return_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   run_cmp = 1'b0;

    always #5 clk = ~clk;

    call_return_if #(.DATA_W(32)) bus ();

    call_return_ctrl #(
        .DATA_W(32), .RET_OFFSET(1), .STACK_DEPTH(15), .CNT_W(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation occupies the controller for a fixed
    // number of cycles after acceptance; a fault blocks until cleared.
    int          busy;
    bit          faulted;
    int          cnt;
    logic        e_push, e_pop, e_rv, e_ov, e_un, e_derr;
    logic [31:0] e_wdata, e_rpc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 0; faulted <= 1'b0; cnt <= 0;
            e_push <= 1'b0; e_pop <= 1'b0; e_rv <= 1'b0;
            e_ov <= 1'b0; e_un <= 1'b0; e_derr <= 1'b0;
            e_wdata <= '0; e_rpc <= '0;
        end else begin
            e_push <= 1'b0; e_pop <= 1'b0; e_rv <= 1'b0;
            if (faulted) begin
                if (bus.fault_clear) begin
                    faulted <= 1'b0; e_ov <= 1'b0; e_un <= 1'b0;
                end
            end else if (busy > 0) begin
                busy <= busy - 1;
            end else begin
`ifdef CALL_RET_DEPTH_CHECK_EN
                if (((cnt == 0) != bus.stk_empty) || ((cnt == 15) != bus.stk_full))
                    e_derr <= 1'b1;
`endif
                if (bus.call_valid) begin
                    if (bus.stk_full) begin
                        faulted <= 1'b1; e_ov <= 1'b1;
                    end else begin
                        busy <= 2; e_push <= 1'b1; e_rv <= 1'b1;
                        e_wdata <= bus.pc_in + 32'd1;
                        e_rpc <= bus.call_target;
                        cnt <= (cnt + 1) % 16;
                    end
                end else if (bus.ret_valid) begin
                    if (bus.stk_empty) begin
                        faulted <= 1'b1; e_un <= 1'b1;
                    end else begin
                        busy <= 2; e_pop <= 1'b1; e_rv <= 1'b1;
                        e_rpc <= bus.stk_rdata;
                        cnt <= (cnt + 15) % 16;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("m_push",  bus.stk_push,        e_push);
            chk("m_pop",   bus.stk_pop,         e_pop);
            chk("m_rv",    bus.redirect_valid,  e_rv);
            chk("m_wdata", bus.stk_wdata,       e_wdata);
            chk("m_rpc",   bus.redirect_pc,     e_rpc);
            chk("m_ov",    bus.fault_overflow,  e_ov);
            chk("m_un",    bus.fault_underflow, e_un);
            chk("m_derr",  bus.depth_err,       e_derr);
            chk("m_stall", bus.stall,
                rst_n & (faulted || busy != 0 || bus.call_valid || bus.ret_valid));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    initial begin
        bus.call_valid = 0; bus.ret_valid = 0; bus.pc_in = '0; bus.call_target = '0;
        bus.fault_clear = 0; bus.stk_rdata = '0; bus.stk_empty = 1; bus.stk_full = 0;
        run_cmp = 1'b1;
        neg;
        chk("rst_push",  bus.stk_push, 1'b0);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_wdata", bus.stk_wdata, 32'h0);
        chk("rst_rpc",   bus.redirect_pc, 32'h0);
        chk("rst_ov",    bus.fault_overflow, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        // CALL
        bus.pc_in = 32'h100; bus.call_target = 32'h200; bus.call_valid = 1;
        neg; chk("t1_stall_req", bus.stall, 1'b1);
        cyc(1); bus.call_valid = 0;
        neg;
        chk("t1_push",  bus.stk_push, 1'b1);
        chk("t1_wdata", bus.stk_wdata, 32'h101);
        chk("t1_rpc",   bus.redirect_pc, 32'h200);
        chk("t1_rv",    bus.redirect_valid, 1'b1);
        chk("t1_stall_push", bus.stall, 1'b1);
        cyc(1); bus.stk_empty = 0;
        neg; chk("t1_push_once", bus.stk_push, 1'b0); chk("t1_stall_settle", bus.stall, 1'b1);
        cyc(1);
        neg; chk("t1_stall_idle", bus.stall, 1'b0);

        // RET
        bus.stk_rdata = 32'h101; bus.ret_valid = 1;
        cyc(1); bus.ret_valid = 0;
        neg;
        chk("t2_pop", bus.stk_pop, 1'b1);
        chk("t2_rv",  bus.redirect_valid, 1'b1);
        chk("t2_rpc", bus.redirect_pc, 32'h101);
        cyc(1); bus.stk_empty = 1;
        neg; chk("t2_pop_once", bus.stk_pop, 1'b0); chk("t2_rv_once", bus.redirect_valid, 1'b0);
        cyc(1);

        // overflow
        bus.stk_full = 1; bus.stk_empty = 0; bus.call_valid = 1;
        cyc(1);
        neg; chk("t3_ov", bus.fault_overflow, 1'b1); chk("t3_nopush", bus.stk_push, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cyc(1);
            neg; chk("t3_stall_hold", bus.stall, 1'b1);
        end
        bus.call_valid = 0; bus.fault_clear = 1;
        cyc(1); bus.fault_clear = 0; bus.stk_full = 0; bus.stk_empty = 1;
        neg; chk("t3_ov_clr", bus.fault_overflow, 1'b0); chk("t3_stall_clr", bus.stall, 1'b0);

        // underflow
        bus.ret_valid = 1;
        cyc(1); bus.ret_valid = 0;
        neg; chk("t4_un", bus.fault_underflow, 1'b1); chk("t4_nopop", bus.stk_pop, 1'b0);
        cyc(1);
        neg; chk("t4_stall_fault", bus.stall, 1'b1);
        bus.fault_clear = 1;
        cyc(1); bus.fault_clear = 0;
        neg; chk("t4_un_clr", bus.fault_underflow, 1'b0);
        // fault_clear outside FAULT must not disturb anything
        bus.fault_clear = 1; cyc(1); bus.fault_clear = 0;

        // CALL and RET together: push first, pop three cycles later
        bus.stk_empty = 0; bus.pc_in = 32'h300; bus.call_target = 32'h400;
        bus.stk_rdata = 32'h555; bus.call_valid = 1; bus.ret_valid = 1;
        cyc(1); bus.call_valid = 0;
        neg; chk("t4b_push", bus.stk_push, 1'b1); chk("t4b_nopop", bus.stk_pop, 1'b0);
        chk("t4b_rpc_call", bus.redirect_pc, 32'h400);
        cyc(1);
        neg; chk("t4b_settle_nopop", bus.stk_pop, 1'b0);
        cyc(1);
        neg; chk("t4b_idle_nopop", bus.stk_pop, 1'b0); chk("t4b_stall_ret", bus.stall, 1'b1);
        cyc(1); bus.ret_valid = 0;
        neg; chk("t4b_pop", bus.stk_pop, 1'b1); chk("t4b_rpc_ret", bus.redirect_pc, 32'h555);
        cyc(2);

        // wrap of the return address
        bus.pc_in = 32'hFFFF_FFFF; bus.call_valid = 1;
        cyc(1); bus.call_valid = 0;
        neg; chk("t5_wrap", bus.stk_wdata, 32'h0000_0000);
        cyc(2);

        // async reset in the middle of a PUSH
        bus.pc_in = 32'h10; bus.call_valid = 1;
        cyc(1); bus.call_valid = 0;
        #2;
        chk("t5_push_pre", bus.stk_push, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_push",  bus.stk_push, 1'b0);
        chk("t5_rst_rv",    bus.redirect_valid, 1'b0);
        chk("t5_rst_stall", bus.stall, 1'b0);
        cyc(1);
        rst_n = 1'b1; bus.stk_empty = 1; bus.stk_full = 0;
        cyc(1);

        // depth check: two pushes while stk_empty stays 1
        neg; chk("t6_derr_clean", bus.depth_err, 1'b0);
        for (int k = 0; k < 2; k++) begin
            bus.pc_in = 32'h20 + 32'(k); bus.call_valid = 1;
            cyc(1); bus.call_valid = 0;
            cyc(2);
        end
        cyc(1);
`ifdef CALL_RET_DEPTH_CHECK_EN
        neg; chk("t6_derr", bus.depth_err, 1'b1);
`else
        neg; chk("t6_derr", bus.depth_err, 1'b0);
`endif
        cyc(1);
        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
